// File: rtl/panda_risc_v_pre_dcd_stage.sv
// Pre-decode stage: per-lane RV32 pre-decode of a fetch bundle, first-jump
// detection with static target computation, and a small output buffer.
module panda_risc_v_pre_dcd_stage #(
    parameter int INST_N    = 2,
    parameter int EN_RV32M  = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_pc,
    input  logic [32*INST_N-1:0]  s_inst,
    input  logic [INST_N-1:0]     s_lane_vld,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_pc,
    output logic [INST_N-1:0]     m_lane_vld,
    output logic [64*INST_N-1:0]  m_msg,
    output logic [INST_N-1:0]     m_illegal,
    output logic                  m_jmp_found,
    output logic [1:0]            m_jmp_lane,
    output logic [31:0]           m_jmp_tgt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic       M_EN    = (EN_RV32M != 0);
    localparam logic [1:0] DEPTH_L = 2'(BUF_DEPTH);

    // Message bit positions of the jump flags
    localparam int MSG_B    = 8;
    localparam int MSG_JAL  = 7;
    localparam int MSG_JALR = 6;

    typedef struct packed {
        logic        illegal;
        logic [63:0] msg;
    } lane_dec_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [INST_N-1:0]    lane_vld;
        logic [64*INST_N-1:0] msg;
        logic [INST_N-1:0]    illegal;
        logic                 jmp_found;
        logic [1:0]           jmp_lane;
        logic [31:0]          jmp_tgt;
    } bundle_t;

    function automatic logic signed [20:0] j_imm(input logic [31:0] inst);
        return $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    endfunction

    function automatic logic signed [20:0] i_imm(input logic [31:0] inst);
        return $signed({{9{inst[31]}}, inst[31:20]});
    endfunction

    function automatic logic signed [20:0] b_imm(input logic [31:0] inst);
        return $signed({{8{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    endfunction

    // Single-lane pre-decode: flags, register usage, jump offset, legality
    function automatic lane_dec_t pre_decode(input logic [31:0] inst);
        logic [6:0]         op;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic               legal;
        logic               rs1_vld, rs2_vld, rd_vld;
        logic               is_b, is_jal, is_jalr, is_csr_rw;
        logic               is_load, is_store, is_mul, is_div, is_rem;
        logic [11:0]        csr_addr;
        logic signed [20:0] ofs;
        lane_dec_t          res;

        op        = inst[6:0];
        f3        = inst[14:12];
        f7        = inst[31:25];
        legal     = 1'b0;
        rs1_vld   = 1'b0;
        rs2_vld   = 1'b0;
        rd_vld    = 1'b0;
        is_b      = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_csr_rw = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_rem    = 1'b0;
        csr_addr  = 12'd0;
        ofs       = '0;

        case (op)
            OP_LUI, OP_AUIPC: begin
                legal  = 1'b1;
                rd_vld = 1'b1;
            end
            OP_JAL: begin
                legal  = 1'b1;
                rd_vld = 1'b1;
                is_jal = 1'b1;
                ofs    = j_imm(inst);
            end
            OP_JALR: begin
                legal   = (f3 == 3'b000);
                rs1_vld = 1'b1;
                rd_vld  = 1'b1;
                is_jalr = 1'b1;
                ofs     = i_imm(inst);
            end
            OP_BRANCH: begin
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
                rs1_vld = 1'b1;
                rs2_vld = 1'b1;
                is_b    = 1'b1;
                ofs     = b_imm(inst);
            end
            OP_LOAD: begin
                legal   = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                rs1_vld = 1'b1;
                rd_vld  = 1'b1;
                is_load = 1'b1;
            end
            OP_STORE: begin
                legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                rs1_vld  = 1'b1;
                rs2_vld  = 1'b1;
                is_store = 1'b1;
            end
            OP_IMM: begin
                // Shifts carry a funct7 that must be a known pattern
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    legal = 1'b1;
                rs1_vld = 1'b1;
                rd_vld  = 1'b1;
            end
            OP_REG: begin
                if (f7 == 7'b0000000)
                    legal = 1'b1;
                else if (f7 == 7'b0100000)
                    legal = (f3 == 3'b000) || (f3 == 3'b101);
                else if (f7 == 7'b0000001)
                    legal = M_EN;
                rs1_vld = 1'b1;
                rs2_vld = 1'b1;
                rd_vld  = 1'b1;
                is_mul  = M_EN & inst[25] & ~inst[14];
                is_div  = M_EN & inst[25] & (inst[14:13] == 2'b10);
                is_rem  = M_EN & inst[25] & (inst[14:13] == 2'b11);
            end
            OP_FENCE: begin
                legal = (f3 == 3'b000) || (f3 == 3'b001);
            end
            OP_SYSTEM: begin
                is_csr_rw = (f3 != 3'b000);
                if (f3 != 3'b000)
                    csr_addr = inst[31:20];
                if (f3 == 3'b000) begin
                    // ecall, ebreak, mret, wfi
                    legal = (inst == 32'h0000_0073) || (inst == 32'h0010_0073) ||
                            (inst == 32'h3020_0073) || (inst == 32'h1050_0073);
                end else if (f3 == 3'b100) begin
                    legal = 1'b0;
                end else begin
                    legal   = 1'b1;
                    rs1_vld = ~f3[2];
                    rd_vld  = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase

        res.illegal = ~legal;
        res.msg     = {19'd0, csr_addr, rs1_vld, rs2_vld, rd_vld, ofs,
                       is_b, is_jal, is_jalr, is_csr_rw, is_load, is_store,
                       is_mul, is_div, is_rem};
        return res;
    endfunction

    // ---- stage p0: combinational pre-decode of the incoming bundle ----
    lane_dec_t          lane_dec_p0 [INST_N];
    bundle_t            dec_p0;
    logic               jmp_found_p0;
    logic [1:0]         jmp_lane_p0;
    logic               jmp_is_jalr_p0;
    logic signed [20:0] jmp_imm_p0;
    logic signed [31:0] jmp_ofs_p0;

    // Decode every lane independently
    always_comb begin
        for (int i = 0; i < INST_N; i++)
            lane_dec_p0[i] = pre_decode(s_inst[32*i +: 32]);
    end

    // Find the first valid jump, trim later lanes and compute its target
    always_comb begin
        dec_p0         = '0;
        jmp_found_p0   = 1'b0;
        jmp_lane_p0    = 2'd0;
        jmp_is_jalr_p0 = 1'b0;
        jmp_imm_p0     = '0;
        jmp_ofs_p0     = '0;
        // Scan downward so the lowest matching lane wins
        for (int i = INST_N - 1; i >= 0; i--) begin
            if (s_lane_vld[i] && (lane_dec_p0[i].msg[MSG_B] || lane_dec_p0[i].msg[MSG_JAL] ||
                                  lane_dec_p0[i].msg[MSG_JALR])) begin
                jmp_found_p0   = 1'b1;
                jmp_lane_p0    = 2'(i);
                jmp_is_jalr_p0 = lane_dec_p0[i].msg[MSG_JALR];
                jmp_imm_p0     = $signed(lane_dec_p0[i].msg[29:9]);
            end
        end
        jmp_ofs_p0 = {{11{jmp_imm_p0[20]}}, jmp_imm_p0};

        dec_p0.pc        = s_pc;
        dec_p0.jmp_found = jmp_found_p0;
        dec_p0.jmp_lane  = jmp_lane_p0;
        // JALR targets depend on a register value and are resolved later
        if (jmp_found_p0 && !jmp_is_jalr_p0)
            dec_p0.jmp_tgt = s_pc + {28'd0, jmp_lane_p0, 2'b00} + $unsigned(jmp_ofs_p0);
        for (int i = 0; i < INST_N; i++) begin
            dec_p0.msg[64*i +: 64] = lane_dec_p0[i].msg;
            dec_p0.illegal[i]      = lane_dec_p0[i].illegal & s_lane_vld[i];
            dec_p0.lane_vld[i]     = s_lane_vld[i] & (~jmp_found_p0 || (i <= int'(jmp_lane_p0)));
        end
    end

    // ---- stage p1: output buffer ----
    // Storage is always two entries; a depth-1 buffer simply never advances its pointers.
    bundle_t    buf_p1 [2];
    bundle_t    out_p1;
    logic [1:0] count_p1;
    logic [1:0] count_nxt;
    logic       wr_ptr_p1;
    logic       rd_ptr_p1;
    logic       push;
    logic       pop;

    function automatic logic ptr_inc(input logic p);
        return (BUF_DEPTH == 2) ? ~p : 1'b0;
    endfunction

    assign m_valid   = (count_p1 != 2'd0);
    assign push      = s_valid & s_ready & ~flush;
    assign pop       = m_valid & m_ready;
    assign count_nxt = count_p1 + {1'b0, push} - {1'b0, pop};

    // Buffer control: occupancy, pointers and the registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_p1  <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            s_ready   <= 1'b0;
        end else if (flush) begin
            count_p1  <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            s_ready   <= 1'b1;
        end else begin
            count_p1 <= count_nxt;
            if (push)
                wr_ptr_p1 <= ptr_inc(wr_ptr_p1);
            if (pop)
                rd_ptr_p1 <= ptr_inc(rd_ptr_p1);
            // Ready looks at next occupancy, so a full buffer popped now reopens next cycle
            s_ready <= (count_nxt < DEPTH_L);
        end
    end

    // Buffer storage; contents are only visible while counted as occupied
    always_ff @(posedge clk) begin
        if (push)
            buf_p1[wr_ptr_p1] <= dec_p0;
    end

    // Zero the outputs whenever nothing is buffered
    always_comb begin
        out_p1 = '0;
        if (m_valid)
            out_p1 = buf_p1[rd_ptr_p1];
    end

    assign m_pc        = out_p1.pc;
    assign m_lane_vld  = out_p1.lane_vld;
    assign m_msg       = out_p1.msg;
    assign m_illegal   = out_p1.illegal;
    assign m_jmp_found = out_p1.jmp_found;
    assign m_jmp_lane  = out_p1.jmp_lane;
    assign m_jmp_tgt   = out_p1.jmp_tgt;

endmodule

// File: tb/tb_panda_risc_v_pre_dcd_stage.sv
// Scoreboard bench for the pre-decode stage: one instance with the M extension,
// one without, both fed the same bundles.
module tb_panda_risc_v_pre_dcd_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush;
    logic         s_valid;
    logic [31:0]  s_pc;
    logic [63:0]  s_inst;
    logic [1:0]   s_lane_vld;
    logic         m_ready;

    logic         s_ready, m_valid, m_jmp_found;
    logic [31:0]  m_pc, m_jmp_tgt;
    logic [1:0]   m_lane_vld, m_illegal, m_jmp_lane;
    logic [127:0] m_msg;

    logic         nm_s_ready, nm_m_valid, nm_m_jmp_found;
    logic [31:0]  nm_m_pc, nm_m_jmp_tgt;
    logic [1:0]   nm_m_lane_vld, nm_m_illegal, nm_m_jmp_lane;
    logic [127:0] nm_m_msg;

    panda_risc_v_pre_dcd_stage #(.INST_N(2), .EN_RV32M(1), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_pc(s_pc), .s_inst(s_inst), .s_lane_vld(s_lane_vld),
        .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_lane_vld(m_lane_vld), .m_msg(m_msg),
        .m_illegal(m_illegal), .m_jmp_found(m_jmp_found), .m_jmp_lane(m_jmp_lane), .m_jmp_tgt(m_jmp_tgt)
    );

    panda_risc_v_pre_dcd_stage #(.INST_N(2), .EN_RV32M(0), .BUF_DEPTH(2)) dut_nm (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(nm_s_ready), .s_pc(s_pc), .s_inst(s_inst), .s_lane_vld(s_lane_vld),
        .m_valid(nm_m_valid), .m_ready(m_ready), .m_pc(nm_m_pc), .m_lane_vld(nm_m_lane_vld), .m_msg(nm_m_msg),
        .m_illegal(nm_m_illegal), .m_jmp_found(nm_m_jmp_found), .m_jmp_lane(nm_m_jmp_lane), .m_jmp_tgt(nm_m_jmp_tgt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0]  pc;
        logic [1:0]   lv;
        logic [127:0] msg;
        logic [1:0]   ill;
        logic         found;
        logic [1:0]   lane;
        logic [31:0]  tgt;
    } exp_t;

    exp_t q_m[$];
    exp_t q_nm[$];

    // Reference decode of one instruction: {illegal, msg}
    function automatic logic [64:0] lane_model(input logic [31:0] x, input bit en_m);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok, r1, r2, rd, b, jal, jalr, csr, ld, st, mul, dv, rm;
        int          v;
        logic [31:0] vb;
        logic [63:0] msg;
        op = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
        ok = 0; r1 = 0; r2 = 0; rd = 0; b = 0; jal = 0; jalr = 0; csr = 0;
        ld = 0; st = 0; mul = 0; dv = 0; rm = 0; v = 0;
        case (op)
            7'h37, 7'h17: begin ok = 1; rd = 1; end
            7'h6F: begin
                ok = 1; rd = 1; jal = 1;
                v = (x[31] ? -(1 << 20) : 0) + (int'(x[19:12]) << 12) + (int'(x[20]) << 11) + (int'(x[30:21]) << 1);
            end
            7'h67: begin
                ok = (f3 == 0); r1 = 1; rd = 1; jalr = 1;
                v = (x[31] ? -2048 : 0) + int'(x[30:20]);
            end
            7'h63: begin
                ok = !(f3 inside {3'd2, 3'd3}); r1 = 1; r2 = 1; b = 1;
                v = (x[31] ? -4096 : 0) + (int'(x[7]) << 11) + (int'(x[30:25]) << 5) + (int'(x[11:8]) << 1);
            end
            7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; r1 = 1; rd = 1; ld = 1; end
            7'h23: begin ok = (f3 <= 2); r1 = 1; r2 = 1; st = 1; end
            7'h13: begin
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                r1 = 1; rd = 1;
            end
            7'h33: begin
                r1 = 1; r2 = 1; rd = 1;
                if (f7 == 0) ok = 1;
                else if (f7 == 7'h20) ok = (f3 == 0 || f3 == 5);
                else if (f7 == 7'h01) ok = en_m;
                mul = en_m && x[25] && !x[14];
                dv  = en_m && x[25] && x[14:13] == 2'b10;
                rm  = en_m && x[25] && x[14:13] == 2'b11;
            end
            7'h0F: ok = (f3 <= 1);
            7'h73: begin
                csr = (f3 != 0);
                if (f3 == 0) ok = x inside {32'h73, 32'h100073, 32'h30200073, 32'h10500073};
                else if (f3 == 4) ok = 0;
                else begin ok = 1; rd = 1; r1 = (f3 < 4); end
            end
            default: ok = 0;
        endcase
        vb = v;
        msg = {19'd0, (csr ? x[31:20] : 12'd0), r1, r2, rd, vb[20:0], b, jal, jalr, csr, ld, st, mul, dv, rm};
        return {!ok, msg};
    endfunction

    function automatic exp_t bundle_model(input logic [31:0] pc, input logic [63:0] inst,
                                          input logic [1:0] lv, input bit en_m);
        exp_t        e;
        logic [64:0] d [2];
        logic [31:0] vb;
        e.pc = pc; e.msg = '0; e.ill = '0; e.found = 0; e.lane = 0; e.tgt = 0; e.lv = lv;
        for (int i = 0; i < 2; i++) begin
            d[i] = lane_model(inst[32*i +: 32], en_m);
            e.msg[64*i +: 64] = d[i][63:0];
            e.ill[i] = lv[i] & d[i][64];
        end
        for (int i = 0; i < 2; i++) begin
            if (!e.found && lv[i] && (d[i][8] || d[i][7] || d[i][6])) begin
                e.found = 1;
                e.lane  = 2'(i);
                vb = {{11{d[i][29]}}, d[i][29:9]};
                e.tgt = d[i][6] ? 32'd0 : pc + 32'(4 * i) + vb;
            end
        end
        if (e.found && e.lane == 0) e.lv[1] = 1'b0;
        return e;
    endfunction

    task automatic compare_bundle(input string who, input exp_t e, input logic [31:0] pc, input logic [1:0] lv,
                                  input logic [127:0] msg, input logic [1:0] ill, input logic found,
                                  input logic [1:0] lane, input logic [31:0] tgt);
        check({who, ".pc"}, pc, e.pc);
        check({who, ".lane_vld"}, lv, e.lv);
        check({who, ".msg"}, msg, e.msg);
        check({who, ".illegal"}, ill, e.ill);
        check({who, ".jmp_found"}, found, e.found);
        check({who, ".jmp_lane"}, lane, e.lane);
        check({who, ".jmp_tgt"}, tgt, e.tgt);
    endtask

    logic         hold_prev = 1'b0;
    logic [31:0]  prev_pc, prev_tgt;
    logic [127:0] prev_msg;
    logic [1:0]   prev_lv;

    // Called at a falling edge after inputs are set: scores this cycle's handshakes
    task automatic tick();
        #1;
        if (hold_prev) begin
            check("hold.valid", m_valid, 1'b1);
            check("hold.pc", m_pc, prev_pc);
            check("hold.msg", m_msg, prev_msg);
            check("hold.lane_vld", m_lane_vld, prev_lv);
            check("hold.tgt", m_jmp_tgt, prev_tgt);
        end
        if (m_valid && m_ready) begin
            if (q_m.size() == 0) check("m.spurious", m_valid, 1'b0);
            else compare_bundle("m", q_m.pop_front(), m_pc, m_lane_vld, m_msg, m_illegal,
                                m_jmp_found, m_jmp_lane, m_jmp_tgt);
        end
        if (nm_m_valid && m_ready) begin
            if (q_nm.size() == 0) check("nm.spurious", nm_m_valid, 1'b0);
            else compare_bundle("nm", q_nm.pop_front(), nm_m_pc, nm_m_lane_vld, nm_m_msg, nm_m_illegal,
                                nm_m_jmp_found, nm_m_jmp_lane, nm_m_jmp_tgt);
        end
        if (flush) begin
            q_m.delete();
            q_nm.delete();
        end else begin
            if (s_valid && s_ready)    q_m.push_back(bundle_model(s_pc, s_inst, s_lane_vld, 1'b1));
            if (s_valid && nm_s_ready) q_nm.push_back(bundle_model(s_pc, s_inst, s_lane_vld, 1'b0));
        end
        hold_prev = m_valid && !m_ready && !flush;
        prev_pc = m_pc; prev_msg = m_msg; prev_lv = m_lane_vld; prev_tgt = m_jmp_tgt;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] l1,
                         input logic [31:0] l0, input logic [1:0] lv);
        s_valid = v; s_pc = pc; s_inst = {l1, l0}; s_lane_vld = lv;
    endtask

    task automatic drain(input string tag);
        s_valid = 0; m_ready = 1;
        for (int k = 0; k < 8; k++) tick();
        check({tag, ".q_m_left"}, q_m.size(), 0);
        check({tag, ".q_nm_left"}, q_nm.size(), 0);
    endtask

    logic [31:0] itab [20] = '{
        32'h0000_0013, 32'h0080_006F, 32'hFE00_0EE3, 32'h02B5_0533, 32'h02B5_4533,
        32'h02B5_6533, 32'h0005_2503, 32'h00A5_2223, 32'h3052_9073, 32'h0005_00E7,
        32'hFFFF_FFFF, 32'h0000_100F, 32'h0000_0073, 32'h40B5_0533, 32'h0000_0537,
        32'h8000_006F, 32'h0000_C063, 32'h0000_A063, 32'h3050_5073, 32'h0015_1513
    };

    localparam logic [31:0] ADDI = 32'h0000_0013;
    int acc_n;

    initial begin
        flush = 0; s_valid = 0; m_ready = 0; s_pc = 0; s_inst = 0; s_lane_vld = 0;

        // Reset state, asserted asynchronously before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst.m_valid", m_valid, 1'b0);
        check("rst.s_ready", s_ready, 1'b0);
        check("rst.m_pc", m_pc, 32'd0);
        check("rst.m_msg", m_msg, 128'd0);
        check("rst.m_jmp_tgt", m_jmp_tgt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst.ready_before_edge", s_ready, 1'b0);
        @(posedge clk);
        #1 check("rst.ready_after_edge", s_ready, 1'b1);
        @(negedge clk);

        // addi + jal +8 at 0x100
        m_ready = 1;
        drive(1, 32'h100, 32'h0080_006F, ADDI, 2'b11);
        tick();
        check("jal.valid", m_valid, 1'b1);
        check("jal.lane_vld", m_lane_vld, 2'b11);
        check("jal.found", m_jmp_found, 1'b1);
        check("jal.lane", m_jmp_lane, 2'd1);
        check("jal.tgt", m_jmp_tgt, 32'h10C);
        check("jal.illegal", m_illegal, 2'b00);

        // beq -4 in lane 0 trims lane 1
        drive(1, 32'h100, ADDI, 32'hFE00_0EE3, 2'b11);
        tick();
        check("beq.valid", m_valid, 1'b1);
        check("beq.lane_vld", m_lane_vld, 2'b01);
        check("beq.lane", m_jmp_lane, 2'd0);
        check("beq.tgt", m_jmp_tgt, 32'hFC);

        // mul with and without the M extension
        drive(1, 32'h200, ADDI, 32'h02B5_0533, 2'b11);
        tick();
        check("mul.m.illegal0", m_illegal[0], 1'b0);
        check("mul.m.is_mul", m_msg[2], 1'b1);
        check("mul.nm.illegal0", nm_m_illegal[0], 1'b1);
        check("mul.nm.is_mul", nm_m_msg[2], 1'b0);

        // Empty bundle passes through
        drive(1, 32'h300, 32'hFFFF_FFFF, 32'h0080_006F, 2'b00);
        tick();
        check("empty.found", m_jmp_found, 1'b0);
        check("empty.illegal", m_illegal, 2'b00);
        drain("directed");

        // Random stream with random backpressure
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  itab[$urandom % 20], itab[$urandom % 20], 2'($urandom));
            m_ready = ($urandom % 4) != 0;
            tick();
        end
        drain("random");

        // Back-pressure: three bundles offered, two fit
        m_ready = 0; acc_n = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h1000 + 32'(acc_n * 8), itab[acc_n + 1], itab[acc_n + 6], 2'b11);
            if (s_ready) acc_n++;
            tick();
        end
        check("bp.accepted", acc_n, 2);
        check("bp.s_ready", s_ready, 1'b0);
        check("bp.m_valid", m_valid, 1'b1);
        s_valid = 0; m_ready = 1;
        check("bp.emit0", m_valid, 1'b1);
        tick();
        check("bp.emit1", m_valid, 1'b1);
        check("bp.ready_back", s_ready, 1'b1);
        tick();
        check("bp.empty", m_valid, 1'b0);
        drain("bp");

        // Flush with two buffered bundles and a simultaneous push
        m_ready = 0;
        drive(1, 32'h2000, ADDI, itab[6], 2'b11); tick();
        drive(1, 32'h2008, ADDI, itab[7], 2'b11); tick();
        drive(1, 32'h2010, ADDI, itab[8], 2'b11); flush = 1; tick();
        flush = 0; s_valid = 0;
        check("flush.m_valid", m_valid, 1'b0);
        check("flush.s_ready", s_ready, 1'b1);
        m_ready = 1;
        drive(1, 32'h3000, itab[2], itab[4], 2'b11); tick();
        drain("flush");

        // Asynchronous reset while data is waiting
        m_ready = 0;
        drive(1, 32'h4000, itab[1], ADDI, 2'b11); tick();
        s_valid = 0;
        check("arst.m_valid_before", m_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst.m_valid", m_valid, 1'b0);
        check("arst.s_ready", s_ready, 1'b0);
        check("arst.m_pc", m_pc, 32'd0);
        check("arst.m_msg", m_msg, 128'd0);
        q_m.delete(); q_nm.delete(); hold_prev = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        check("arst.ready_before_edge", s_ready, 1'b0);
        @(posedge clk);
        #1 check("arst.ready_after_edge", s_ready, 1'b1);
        check("arst.still_empty", m_valid, 1'b0);
        @(negedge clk);
        m_ready = 1;
        drive(1, 32'h5000, itab[9], itab[3], 2'b11); tick();
        drain("arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/panda_risc_v_pre_dcd_stage.md
PANDA_RISC_V_PRE_DCD_STAGE -- requirements
Module: panda_risc_v_pre_dcd_stage

Interface
REQ-001 SHALL have parameter INST_N, default 2, meaning instructions per fetch bundle (legal 1..4).
REQ-002 SHALL have parameter EN_RV32M, default 1, meaning 1 = M-extension legal, 0 = every M encoding (opcode 0110011, inst[25]=1) is illegal and its mul/div/rem flags are 0.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, meaning output buffer entries (legal 1 or 2; 1 = half throughput, 2 = full throughput).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-005 SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-high.
REQ-006 SHALL have port flush, input, 1 bit, meaning discard all buffered and incoming bundles.
REQ-007 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_pc (input, 32), s_inst (input, 32*INST_N, lane i at [32i+31:32i]) and s_lane_vld (input, INST_N), together forming the bundle input.
REQ-008 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_pc (output, 32), m_lane_vld (output, INST_N), m_msg (output, 64*INST_N), m_illegal (output, INST_N), m_jmp_found (output, 1), m_jmp_lane (output, 2) and m_jmp_tgt (output, 32), together forming the bundle output.

Function
REQ-009 SHALL pre-decode each lane combinationally into a 64-bit message packed as {19'd0, csr_addr[11:0], rs1_vld, rs2_vld, rd_vld, jump_ofs_imm[20:0], is_b, is_jal, is_jalr, is_csr_rw, is_load, is_store, is_mul, is_div, is_rem}, MSB first.
REQ-010 SHALL decode the opcodes as B=1100011, JAL=1101111, JALR=1100111, LOAD=0000011, STORE=0100011; set is_csr_rw when opcode is 1110011 and funct3≠000; set mul when opcode is 0110011, inst[25]=1 and inst[14]=0; set div when additionally inst[14:13]=10; set rem when additionally inst[14:13]=11.
REQ-011 SHALL form jump_ofs_imm as the sign-extended offset: JAL J-immediate, JALR I-immediate, B B-immediate; it SHALL be 0 for all other opcodes.
REQ-012 SHALL set rs1/rs2/rd valid and illegal per RV32I+Zicsr+fence/fence.i (plus M when EN_RV32M=1); illegal SHALL be forced to 0 for lanes with s_lane_vld=0.
REQ-013 SHALL set m_jmp_lane to the lowest valid lane that is B, JAL or JALR, and m_jmp_found=1 if such a lane exists.
REQ-014 SHALL clear m_lane_vld bits above m_jmp_lane; bits at or below it SHALL be kept.
REQ-015 SHALL compute m_jmp_tgt = s_pc + 4*m_jmp_lane + jump_ofs_imm (sign-extended to 32 bits, mod 2^32) for B/JAL; for JALR it SHALL output 0, since it is resolved downstream; with no jump found it SHALL output 0.
REQ-016 SHALL accept a bundle on s_valid & s_ready and store its decoded result in a FIFO of BUF_DEPTH entries; latency from accept to m_valid SHALL be 1 cycle.
REQ-017 SHALL drive s_ready = buffer not full (registered); with BUF_DEPTH=2, a full buffer popped in a cycle still deasserts s_ready that cycle, and s_ready reasserts the next cycle.
REQ-018 SHALL drive m_valid = buffer not empty; it SHALL pop on m_valid & m_ready, and simultaneous push and pop SHALL keep occupancy unchanged.
REQ-019 SHALL hold m_* outputs stable while m_valid=1 and m_ready=0.
REQ-020 SHALL accept a bundle with s_lane_vld=0 and pass it through with m_jmp_found=0 and m_illegal=0.
REQ-021 SHALL, on flush=1, empty the buffer at the next edge, ignore any push in that cycle, drop m_valid the next cycle, and reassert s_ready the next cycle.

Reset
REQ-022 SHALL, while rst=1, hold m_valid=0, s_ready=0 and all m_* data at 0, with the buffer empty.
REQ-023 SHALL assert s_ready the first clk edge after rst deasserts.
REQ-024 SHALL empty the buffer when rst is asserted mid-transfer, with no output of partial data.

Verification
REQ-025 SHALL cover: INST_N=2, pc=0x100, lane0=0x00000013 (addi), lane1=0x0080006F (jal +8), m_ready=1 -> m_lane_vld=11, m_jmp_found=1, m_jmp_lane=1, m_jmp_tgt=0x10C, m_illegal=00.
REQ-026 SHALL cover: lane0=0xFE000EE3 (beq -4), lane1=addi -> m_lane_vld=01, m_jmp_lane=0, m_jmp_tgt=pc-4.
REQ-027 SHALL cover: EN_RV32M=0, lane0=0x02B50533 (mul) -> m_illegal[0]=1 and msg bit2 (is_mul)=0; the same with EN_RV32M=1 -> illegal=0 and is_mul=1.
REQ-028 SHALL cover: BUF_DEPTH=2, m_ready=0 with 3 bundles offered -> 2 accepted, s_ready=0, data stable; then m_ready=1 -> bundles emitted in order, one per cycle.
REQ-029 SHALL cover: 2 bundles buffered, flush pulsed together with s_valid=1 -> next cycle m_valid=0 and s_ready=1, and no flushed bundle ever appears.
REQ-030 SHALL cover: rst asserted asynchronously between edges while m_valid=1 -> m_valid=0 immediately, and s_ready=1 one edge after release.
